// File: rtl/nac_stream_prefetcher_bounded.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | nac_stream_prefetcher_bounded                                            |
// | Credit-checked, 4KB-page-safe burst read prefetcher feeding a FIFO.      |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module nac_stream_prefetcher_bounded #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 32,
  parameter int BURST_LEN  = 16,
  parameter int FIFO_DEPTH = 64,
  parameter int LEN_W      = 24
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [LEN_W-1:0]  total_words,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_len,
  output logic              mem_req,
  input  logic              mem_grant,
  input  logic              mem_valid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] stream_data,
  output logic              stream_valid,
  input  logic              stream_ready,
  output logic              stream_last,
  output logic              busy,
  output logic              done,
  output logic              overflow_err
);

  localparam int BSH = $clog2(DATA_W / 8);
  localparam int PW  = $clog2(FIFO_DEPTH);
  localparam int CW  = PW + 1;
  localparam int MW  = (LEN_W > 13) ? LEN_W : 13;
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'((1 << BSH) - 1);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_REQ, S_DONE} state_t;

  state_t            state;
  logic [ADDR_W-1:0] cur_addr;
  logic [LEN_W-1:0]  req_left;
  logic [LEN_W-1:0]  pop_left;
  logic [8:0]        size_r;
  logic [CW-1:0]     count;
  logic [CW-1:0]     outstanding;
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [DATA_W-1:0] fifo_mem [FIFO_DEPTH];

  logic [12:0]   wub;
  logic [12:0]   lim;
  logic [MW-1:0] size_full;
  logic [8:0]    size_c;
  logic [CW:0]   credit;
  logic          push;
  logic          pop;
  logic          grant_acc;

  // Words left before the 4KB page boundary bound the burst, as do BURST_LEN and req_left.
  assign wub       = (13'd4096 - {1'b0, cur_addr[11:0]}) >> BSH;
  assign lim       = (13'(BURST_LEN) < wub) ? 13'(BURST_LEN) : wub;
  assign size_full = (MW'(req_left) < MW'(lim)) ? MW'(req_left) : MW'(lim);
  assign size_c    = 9'(size_full);
  assign credit    = (CW+1)'(FIFO_DEPTH) - (CW+1)'(count) - (CW+1)'(outstanding);

  assign grant_acc    = (state == S_REQ) && mem_grant;
  assign push         = mem_valid && (outstanding != '0) && (count != CW'(FIFO_DEPTH));
  assign stream_valid = (count != '0);
  assign pop          = stream_valid && stream_ready;
  assign stream_data  = stream_valid ? fifo_mem[rd_ptr] : '0;
  assign stream_last  = stream_valid && (pop_left == LEN_W'(1));
  assign busy         = enable && ((state == S_CALC) || (state == S_REQ));

  always_ff @(posedge clk) begin
    if (push && enable) fifo_mem[wr_ptr] <= mem_rdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      cur_addr     <= '0;
      req_left     <= '0;
      pop_left     <= '0;
      size_r       <= '0;
      count        <= '0;
      outstanding  <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      mem_addr     <= '0;
      mem_len      <= '0;
      mem_req      <= 1'b0;
      done         <= 1'b0;
      overflow_err <= 1'b0;
    end else if (!enable) begin
      state        <= S_IDLE;
      cur_addr     <= '0;
      req_left     <= '0;
      pop_left     <= '0;
      size_r       <= '0;
      count        <= '0;
      outstanding  <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      mem_addr     <= '0;
      mem_len      <= '0;
      mem_req      <= 1'b0;
      done         <= 1'b0;
      overflow_err <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          cur_addr <= start_addr & ALIGN_MASK;
          req_left <= total_words;
          pop_left <= total_words;
          if (total_words == '0) begin
            state <= S_DONE;
            done  <= 1'b1;
          end else begin
            state <= S_CALC;
          end
        end
        S_CALC: begin
          if ((req_left != '0) && (32'(credit) >= 32'(size_c))) begin
            mem_addr <= cur_addr;
            mem_len  <= 8'(size_c - 9'd1);
            size_r   <= size_c;
            mem_req  <= 1'b1;
            state    <= S_REQ;
          end
        end
        S_REQ: begin
          if (mem_grant) begin
            cur_addr <= cur_addr + (ADDR_W'(size_r) << BSH);
            req_left <= req_left - LEN_W'(size_r);
            mem_req  <= 1'b0;
            state    <= S_CALC;
          end
        end
        default: begin
        end
      endcase

      // The final pop ends the operation regardless of where the request side sits.
      if (pop) begin
        pop_left <= pop_left - LEN_W'(1);
        if (pop_left == LEN_W'(1)) begin
          state   <= S_DONE;
          done    <= 1'b1;
          mem_req <= 1'b0;
        end
      end

      count       <= count + CW'(push) - CW'(pop);
      outstanding <= outstanding + (grant_acc ? CW'(size_r) : '0) - CW'(push);
      wr_ptr      <= wr_ptr + PW'(push);
      rd_ptr      <= rd_ptr + PW'(pop);
      if (mem_valid && !push) overflow_err <= 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_nac_stream_prefetcher_bounded.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_nac_stream_prefetcher_bounded                                         |
// | Directed vector bench with a latency-based memory model.                 |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_nac_stream_prefetcher_bounded;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [31:0] start_addr;
  logic [23:0] total_words;
  logic [31:0] mem_addr;
  logic [7:0]  mem_len;
  logic        mem_req;
  logic        mem_grant;
  logic        mem_valid;
  logic [31:0] mem_rdata;
  logic [31:0] stream_data;
  logic        stream_valid;
  logic        stream_ready;
  logic        stream_last;
  logic        busy;
  logic        done;
  logic        overflow_err;

  nac_stream_prefetcher_bounded #(
    .DATA_W(32), .ADDR_W(32), .BURST_LEN(16), .FIFO_DEPTH(32), .LEN_W(24)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .start_addr(start_addr),
    .total_words(total_words), .mem_addr(mem_addr), .mem_len(mem_len),
    .mem_req(mem_req), .mem_grant(mem_grant), .mem_valid(mem_valid),
    .mem_rdata(mem_rdata), .stream_data(stream_data), .stream_valid(stream_valid),
    .stream_ready(stream_ready), .stream_last(stream_last), .busy(busy),
    .done(done), .overflow_err(overflow_err)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] a; int t; } beat_t;
  typedef struct {
    logic [31:0]       start;
    logic [23:0]       total;
    int                nb;
    logic [2:0][31:0]  ba;
    logic [2:0][7:0]   bl;
  } vec_t;

  beat_t       bq[$];
  logic [31:0] log_addr[$];
  logic [7:0]  log_len[$];
  vec_t        vecs[7];
  int          cyc, lat, pops, pop_err, last_err, inflight, peak, total_cur;
  int          n_checks, n_pass;
  bit          grant_en, saw_req;
  logic [31:0] exp_base;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // One clock: log what the DUT saw at the edge, then drive the memory side.
  task automatic tick();
    bit g, p;
    logic [31:0] ga, pd;
    logic [7:0] gl;
    logic pl;
    g = mem_req && mem_grant; ga = mem_addr; gl = mem_len;
    p = stream_valid && stream_ready; pd = stream_data; pl = stream_last;
    @(posedge clk); #1;
    cyc++;
    if (g) begin
      log_addr.push_back(ga);
      log_len.push_back(gl);
      for (int k = 0; k <= int'(gl); k++) bq.push_back('{a: ga + 32'(4 * k), t: cyc + lat});
      inflight += int'(gl) + 1;
    end
    if (p) begin
      if (pd !== exp_base + 32'(4 * pops)) pop_err++;
      if (pl !== 1'((pops + 1) == total_cur)) last_err++;
      pops++;
      inflight--;
    end
    if (inflight > peak) peak = inflight;
    if (mem_req) saw_req = 1'b1;
    mem_grant = grant_en && mem_req;
    if (bq.size() > 0 && bq[0].t <= cyc) begin
      mem_valid = 1'b1;
      mem_rdata = bq[0].a;
      void'(bq.pop_front());
    end else begin
      mem_valid = 1'b0;
      mem_rdata = '0;
    end
  endtask

  task automatic start_op(input logic [31:0] s, input logic [23:0] t);
    log_addr.delete(); log_len.delete(); bq.delete();
    pops = 0; pop_err = 0; last_err = 0; inflight = 0; peak = 0; saw_req = 1'b0;
    exp_base = s & ~32'h3;
    total_cur = int'(t);
    start_addr = s; total_words = t; enable = 1'b1;
  endtask

  task automatic run_until_done(input int budget, output bit timed_out, output bit done_ok);
    int n, p0;
    n = 0; done_ok = 1'b0;
    while (!done && n < budget) begin
      p0 = pops;
      tick();
      n++;
      if (done) done_ok = (pops == total_cur) && (p0 != pops);
    end
    timed_out = !done;
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    bit to, dok;
    start_op(v.start, v.total);
    tick();
    if (v.total == 0) begin
      check({tag, "_zero_done"}, done, 1);
      check({tag, "_zero_busy"}, busy, 0);
      repeat (4) tick();
    end else begin
      check({tag, "_busy"}, busy, 1);
      tick();
      check({tag, "_first_req"}, mem_req, 1);
      run_until_done(600, to, dok);
      check({tag, "_done_timeout"}, to, 0);
      check({tag, "_done_timing"}, dok, 1);
    end
    check({tag, "_any_req"}, saw_req, (v.total != 0));
    check({tag, "_bursts"}, log_addr.size(), v.nb);
    for (int i = 0; i < v.nb; i++) begin
      check($sformatf("%s_b%0d_addr", tag, i), (i < log_addr.size()) ? log_addr[i] : 'x, v.ba[i]);
      check($sformatf("%s_b%0d_len", tag, i), (i < log_len.size()) ? log_len[i] : 'x, v.bl[i]);
    end
    check({tag, "_pops"}, pops, v.total);
    check({tag, "_pop_data_errs"}, pop_err, 0);
    check({tag, "_last_errs"}, last_err, 0);
    check({tag, "_ovf"}, overflow_err, 0);
    enable = 1'b0;
    tick();
    check({tag, "_done_clear"}, done, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    bit to, dok;
    int n;
    vec_t v6;
    rst = 1'b1; enable = 1'b0; start_addr = '0; total_words = '0;
    mem_grant = 1'b0; mem_valid = 1'b0; mem_rdata = '0; stream_ready = 1'b1;
    grant_en = 1'b1; lat = 3; cyc = 0; n_checks = 0; n_pass = 0;

    vecs[0] = '{start: 32'h1000, total: 24'd40, nb: 3,
                ba: {32'h1080, 32'h1040, 32'h1000}, bl: {8'd7, 8'd15, 8'd15}};
    vecs[1] = '{start: 32'h0FF0, total: 24'd16, nb: 2,
                ba: {32'h0, 32'h1000, 32'h0FF0}, bl: {8'd0, 8'd11, 8'd3}};
    vecs[2] = '{start: 32'h2000, total: 24'd5, nb: 1,
                ba: {32'h0, 32'h0, 32'h2000}, bl: {8'd0, 8'd0, 8'd4}};
    vecs[3] = '{start: 32'h2000, total: 24'd0, nb: 0,
                ba: {32'h0, 32'h0, 32'h0}, bl: {8'd0, 8'd0, 8'd0}};
    vecs[4] = '{start: 32'hFFFF_FFF8, total: 24'd4, nb: 2,
                ba: {32'h0, 32'h0, 32'hFFFF_FFF8}, bl: {8'd0, 8'd1, 8'd1}};
    vecs[5] = '{start: 32'h1003, total: 24'd3, nb: 1,
                ba: {32'h0, 32'h0, 32'h1000}, bl: {8'd0, 8'd0, 8'd2}};
    vecs[6] = '{start: 32'h0FC0, total: 24'd20, nb: 2,
                ba: {32'h0, 32'h1000, 32'h0FC0}, bl: {8'd0, 8'd3, 8'd15}};

    repeat (2) @(posedge clk);
    #1;
    check("rst_mem_req", mem_req, 0);
    check("rst_stream_valid", stream_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_ovf", overflow_err, 0);
    check("rst_mem_len", mem_len, 0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 7; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Grant withheld: request and its address/length stay put.
    grant_en = 1'b0; lat = 3;
    start_op(32'h8000, 24'd5);
    repeat (6) tick();
    check("hold_req", mem_req, 1);
    check("hold_addr", mem_addr, 32'h8000);
    check("hold_len", mem_len, 4);
    check("hold_no_grant", log_addr.size(), 0);
    grant_en = 1'b1;
    run_until_done(200, to, dok);
    check("hold_done_timeout", to, 0);
    check("hold_pops", pops, 5);
    check("hold_pop_data_errs", pop_err, 0);
    enable = 1'b0;
    tick();

    // Credit limit: consumer stalled, slow memory.
    lat = 20; stream_ready = 1'b0;
    start_op(32'h4000, 24'd64);
    repeat (70) tick();
    check("credit_bursts_stalled", log_addr.size(), 2);
    check("credit_peak_stalled", peak, 32);
    check("credit_valid", stream_valid, 1);
    check("credit_no_req", mem_req, 0);
    check("credit_ovf", overflow_err, 0);
    stream_ready = 1'b1;
    run_until_done(800, to, dok);
    check("credit_done_timeout", to, 0);
    check("credit_done_timing", dok, 1);
    check("credit_bursts_total", log_addr.size(), 4);
    check("credit_pops", pops, 64);
    check("credit_pop_data_errs", pop_err, 0);
    check("credit_last_errs", last_err, 0);
    check("credit_peak", peak, 32);
    check("credit_ovf_end", overflow_err, 0);
    enable = 1'b0;
    tick();

    // Enable dropped with data buffered and beats outstanding.
    lat = 2; stream_ready = 1'b0;
    start_op(32'h5000, 24'd48);
    n = 0;
    while ((log_addr.size() < 2 || !stream_valid) && n < 40) begin
      tick();
      n++;
    end
    check("drop_setup_valid", stream_valid, 1);
    enable = 1'b0;
    bq.delete();
    tick();
    check("drop_stream_valid", stream_valid, 0);
    check("drop_mem_req", mem_req, 0);
    check("drop_busy", busy, 0);
    check("drop_last", stream_last, 0);
    stream_ready = 1'b1; lat = 3;
    v6 = '{start: 32'h6000, total: 24'd8, nb: 1,
           ba: {32'h0, 32'h0, 32'h6000}, bl: {8'd0, 8'd0, 8'd7}};
    run_vec(v6, "reenable");

    // Stray beat with nothing outstanding.
    start_op(32'h7000, 24'd0);
    tick();
    mem_valid = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    tick();
    check("ovf_set", overflow_err, 1);
    check("ovf_no_push", stream_valid, 0);
    repeat (3) tick();
    check("ovf_sticky", overflow_err, 1);
    enable = 1'b0;
    tick();
    check("ovf_clear", overflow_err, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
